decoder_scan_driver: RTL

- Upstream sequencer for the 2:4 active-low decoder.
- Generates the active-low enable `en` and select lines `a` (MSB) and `b` (LSB) so the decoder scans its four outputs round-robin.
- Each channel gets a programmable dwell time; blanking cycles with `en` high sit between channels so select changes never glitch a live output.
- A channel mask skips unused outputs. Typical use: digit/row scanning for a display or a multiplexed load.

---
 rtl/decoder_scan_pkg.sv | 26 ++
 rtl/decoder_scan_driver_rr_pick4.sv | 40 ++++
 rtl/decoder_scan_driver.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/decoder_scan_pkg.sv
`default_nettype none
// ============================================================================
// Module      : decoder_scan_pkg
// Description : Shared types and constants for the 2:4 decoder scan driver.
//               Holds the scan state encoding, the channel count, default
//               dwell/blank lengths and a small integer max helper.
// Revision    : 1.0  initial release
// ============================================================================
package decoder_scan_pkg;

    localparam int NUM_CH            = 4;
    localparam int DEFAULT_DWELL_CYC = 1000;
    localparam int DEFAULT_BLANK_CYC = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_DWELL = 2'd2
    } scan_state_t;

    function automatic int max2(input int x, input int y);
        return (x > y) ? x : y;
    endfunction

endpackage
`default_nettype wire

// File: rtl/decoder_scan_driver_rr_pick4.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick4
// Description : Combinational round-robin picker over four channels.
//               Searches mask upward from cur+1 with wrap; cur itself is
//               checked last so a single-bit mask reselects the same channel.
// Ports       : mask  [3:0] in  - candidate channels
//               cur   [1:0] in  - last selected channel
//               next  [1:0] out - chosen channel (cur when nothing is set)
//               valid       out - at least one mask bit set
// Revision    : 1.0  initial release
// ============================================================================
module rr_pick4
    import decoder_scan_pkg::*;
(
    input  logic [3:0] mask,
    input  logic [1:0] cur,
    output logic [1:0] next,
    output logic       valid
);

    logic [1:0] w_idx;

    // Walk offsets from farthest (k=4, i.e. cur itself) to nearest (k=1);
    // the last hit overwrites earlier ones, so the nearest set bit wins.
    always_comb begin
        next  = cur;
        valid = 1'b0;
        w_idx = 2'd0;
        for (int k = NUM_CH; k >= 1; k--) begin
            w_idx = cur + 2'(k);
            if (mask[w_idx]) begin
                next  = w_idx;
                valid = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/decoder_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : decoder_scan_driver
// Description : Round-robin scan sequencer for a 2:4 active-low decoder.
//               Each selected channel is preceded by BLANK_CYC cycles with
//               en high (select lines settle) and then held with en low for
//               DWELL_CYC cycles. Unmasked channels are skipped.
// Ports       : clk        in  - system clock, rising edge
//               rst_n      in  - asynchronous active-low reset
//               run        in  - level-sensitive scan request
//               ch_mask    in  - bit i enables channel i
//               hold       in  - (DECODER_SCAN_HOLD_EN only) freeze dwell
//               en         out - active-low decoder enable (registered)
//               a / b      out - select MSB / LSB (registered)
//               ch_strobe  out - one-cycle pulse on first dwell cycle
//               busy       out - high in BLANK or DWELL
// Options     : define DECODER_SCAN_HOLD_EN to add the hold input.
// Revision    : 1.0  initial release
// ============================================================================
module decoder_scan_driver
    import decoder_scan_pkg::*;
#(
    parameter int DWELL_CYC = DEFAULT_DWELL_CYC,
    parameter int BLANK_CYC = DEFAULT_BLANK_CYC
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic [3:0] ch_mask,
`ifdef DECODER_SCAN_HOLD_EN
    input  logic       hold,
`endif
    output logic       en,
    output logic       a,
    output logic       b,
    output logic       ch_strobe,
    output logic       busy
);

    localparam int CNT_W = $clog2(max2(DWELL_CYC, BLANK_CYC) + 1);
    localparam logic [CNT_W-1:0] c_dwell_load = CNT_W'(DWELL_CYC - 1);
    localparam logic [CNT_W-1:0] c_blank_load = CNT_W'(BLANK_CYC - 1);
    localparam logic [CNT_W-1:0] c_one        = CNT_W'(1);

    scan_state_t      r_state;
    logic [1:0]       r_cur;
    logic [CNT_W-1:0] r_cnt;
    logic             r_en;
    logic             r_a;
    logic             r_b;
    logic             r_strobe;
    logic             r_busy;

    logic [1:0]       w_next;
    logic             w_valid;
    logic             w_hold;

`ifdef DECODER_SCAN_HOLD_EN
    assign w_hold = hold;
`else
    assign w_hold = 1'b0;
`endif

    rr_pick4 u_pick (
        .mask  (ch_mask),
        .cur   (r_cur),
        .next  (w_next),
        .valid (w_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_cur    <= 2'd3;        // first search then starts at channel 0
            r_cnt    <= '0;
            r_en     <= 1'b1;
            r_a      <= 1'b0;
            r_b      <= 1'b0;
            r_strobe <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_strobe <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (run && w_valid) begin
                        r_state <= ST_BLANK;
                        r_cur   <= w_next;
                        r_a     <= w_next[1];
                        r_b     <= w_next[0];
                        r_cnt   <= c_blank_load;
                        r_busy  <= 1'b1;
                    end
                end
                ST_BLANK: begin
                    if (!run) begin
                        // abandon before en ever goes low; select lines held
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else if (r_cnt == '0) begin
                        r_state  <= ST_DWELL;
                        r_en     <= 1'b0;
                        r_strobe <= 1'b1;
                        r_cnt    <= c_dwell_load;
                    end else begin
                        r_cnt <= r_cnt - c_one;
                    end
                end
                ST_DWELL: begin
                    // run is ignored until the dwell has fully elapsed
                    if (w_hold) begin
                        r_cnt <= r_cnt;
                    end else if (r_cnt == '0) begin
                        r_en <= 1'b1;
                        if (run && w_valid) begin
                            r_state <= ST_BLANK;
                            r_cur   <= w_next;
                            r_a     <= w_next[1];
                            r_b     <= w_next[0];
                            r_cnt   <= c_blank_load;
                        end else begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt - c_one;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_en    <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign en        = r_en;
    assign a         = r_a;
    assign b         = r_b;
    assign ch_strobe = r_strobe;
    assign busy      = r_busy;

endmodule
`default_nettype wire
